uart_rx: RTL and testbench
==========================

# uart_rx

8N1 UART receiver, the receive half of the UART link on the DE10 (50 MHz clk, 115200 baud default). It synchronises the asynchronous serial input and validates the start bit at mid-bit. It samples 8 data bits LSB-first at bit centres, checks the stop bit, and presents each good byte on a valid/ready output with framing-error and overrun reporting.

## Interface
- CLKS_PER_BIT, default 434: clk cycles per serial bit (N); must be ≥ 4. H = N/2 (integer division), 217 by default.
- clk  in  1  system clock, 50 MHz.
- rstn  in  1  reset, synchronous, active-low.
- rx_i  in  1  asynchronous serial line, idle high.
- rx_data  out  8  received byte; valid while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts; transfer occurs when rx_valid & rx_ready at a clk edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the output was still full.

## Operation
- Input path:
  - Two-flop synchroniser: s1 <= rx_i, then s2 <= s1.
  - History flop: prev <= s2.
  - All three flops reset to 1.
  - fall = prev & ~s2.
- Baud counter cnt: width $clog2(N), cleared on every state entry, incremented each cycle otherwise.
- State machine: IDLE, START, DATA, STOP; reset state IDLE.
  - IDLE: on fall, go to START.
  - START: when cnt == H-1, sample s2.
    - If s2 = 1 (glitch), go to IDLE; nothing is reported.
    - If s2 = 0, clear the bit index and go to DATA.
  - DATA: when cnt == N-1, shift s2 into the data shift register MSB (right shift, so the first bit lands in bit 0 after 8 shifts) and increment the 3-bit bit index. After the 8th sample, go to STOP.
  - STOP: when cnt == N-1, sample s2 and go to IDLE.
    - s2 = 1: deliver the byte (see the output rules below).
    - s2 = 0: pulse frame_err and discard the byte.
- Re-arming requires a new 1→0 transition on s2. A line held low (break) produces exactly one frame_err and no further activity until the line returns high and falls again.
- Output register rules at a delivery event:
  - rx_valid = 0: load rx_data, set rx_valid.
  - rx_valid = 1 and rx_ready = 1 in the same cycle: the old byte transfers, the new byte loads, rx_valid stays 1, no overrun.
  - rx_valid = 1 and rx_ready = 0: keep the old byte, drop the new one, pulse overrun.
- With no delivery event, rx_valid & rx_ready clears rx_valid. rx_data holds its last value.
- Reset at any point, including mid-frame:
  - State IDLE, cnt 0.
  - rx_valid 0, rx_data 8'h00, frame_err 0, overrun 0.
  - Synchroniser flops at 1, so there is no false start after reset.

## Timing
- Edge numbering: edge 0 is the first clk edge that samples rx_i low.
  - s2 is low after edge 1, so fall is true during the cycle after edge 1.
  - START is entered at edge 2.
- Start sample at edge 2+H. Data sample k (k = 0..7) at edge 2+H+(k+1)·N. Stop sample at edge 2+H+9N.
- rx_valid / frame_err / overrun are asserted in the cycle after edge 2+H+9N. With defaults that is edge 4125.
- frame_err and overrun are high for exactly one cycle. The receiver is back in IDLE in that same cycle.
- Back-to-back frames: a start edge arriving immediately after the stop sample is accepted with no lost bits. The IDLE dwell is 0 cycles beyond fall detection.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package uart_pkg holds:
  - typedef enum logic [1:0] uart_rx_state_t {IDLE, START, DATA, STOP}
  - localparam UART_DATA_BITS = 8
  - localparam UART_CLKS_PER_BIT_DEFAULT = 434
- Sub-module uart_rx_sync: the 2-flop synchroniser plus history flop. It outputs s2 and fall and resets to the idle-high state.
- The FSM, counter, shift register and output register live in uart_rx.

## Test plan
- Reset then frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first, stop 1) at N=434, rx_ready=0 → rx_valid rises after edge 4125, rx_data=0xA5, frame_err=0; rx_ready pulse clears rx_valid next cycle.
- Glitch: rx_i low for 100 cycles then high → state returns to IDLE; no rx_valid, frame_err or overrun; a following 0x3C frame is received correctly.
- Stop bit forced 0 on 0x55, line then held low 20 bit times → a single one-cycle frame_err, rx_valid stays 0; after the line goes high, a 0x0F frame is received normally.
- Two back-to-back frames 0x12 then 0x34 with rx_ready=0 → rx_data=0x12 stays valid and one overrun pulse occurs at the second delivery. Repeat with rx_ready=1 held at the second delivery → rx_data=0x34, no overrun.
- rstn asserted during data bit 4 of 0xFF → all outputs at reset values the next cycle; no delivery from the aborted frame; the next 0x81 frame is received correctly.
- CLKS_PER_BIT=16 (H=8), frames 0x00 and 0xFF at exactly 16 cycles/bit and at ±3% bit period → both bytes received correctly in all three cases.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state type and constants for the UART receiver.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_CLKS_PER_BIT_DEFAULT = 434;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser plus history flop for the serial input.
// All flops reset high so a line idling high never looks like a start edge.
module uart_rx_sync (
    input  logic clk,
    input  logic rstn,
    input  logic rx_i,
    output logic s2_o,
    output logic fall_o
);
    logic s1_q, s2_q, prev_q;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= rx_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end
    assign s2_o   = s2_q;
    assign fall_o = prev_q & ~s2_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with mid-bit start validation, centre sampling,
// stop-bit check and a single-entry valid/ready output register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      frame_err,
    output logic                      overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    logic                      s2, fall;
    uart_rx_state_t            state_q;
    logic [CW-1:0]             cnt_q;
    logic [2:0]                idx_q;
    logic [UART_DATA_BITS-1:0] shift_q, data_q;
    logic                      valid_q, ferr_q, ovr_q;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .rx_i   (rx_i),
        .s2_o   (s2),
        .fall_o (fall)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            cnt_q  <= cnt_q + 1'b1;
            if (valid_q && rx_ready)
                valid_q <= 1'b0;
            case (state_q)
                IDLE: if (fall) begin
                    state_q <= START;
                    cnt_q   <= '0;
                end
                START: if (cnt_q == HALF_LAST) begin
                    cnt_q   <= '0;
                    idx_q   <= '0;
                    state_q <= s2 ? IDLE : DATA;
                end
                DATA: if (cnt_q == BIT_LAST) begin
                    cnt_q   <= '0;
                    shift_q <= {s2, shift_q[UART_DATA_BITS-1:1]};
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == 3'd7)
                        state_q <= STOP;
                end
                STOP: if (cnt_q == BIT_LAST) begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                    // A full register still accepts the new byte if the old one leaves this cycle
                    if (!s2)
                        ferr_q <= 1'b1;
                    else if (!valid_q || rx_ready) begin
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
                    end else
                        ovr_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: checks uart_rx at N=434 (directed corner cases) and N=16
// (table of exact/jittered frames plus a randomised scoreboard run).
module tb_uart_rx;
    logic       clk = 1'b0, rstn = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, ready_a = 1'b0, ready_b = 1'b0;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b, fe_a, fe_b, ovr_a, ovr_b;

    int tests = 0, fails = 0, cyc = 0;
    int t0_a, t0_b, rise_a = 0;
    int fe_ev_a = 0, fe_hi_a = 0, ovr_ev_a = 0, ovr_hi_a = 0;
    int fe_ev_b = 0, fe_hi_b = 0, ovr_ev_b = 0, ovr_hi_b = 0;
    logic fe_pa = 1'b0, ovr_pa = 1'b0, va_p = 1'b0, fe_pb = 1'b0, ovr_pb = 1'b0;
    logic [7:0] acc_a[$], acc_b[$], exp_q[$];

    typedef struct { logic [7:0] d; int per; logic [7:0] exp; } vec_t;
    vec_t tbl [6];

    uart_rx dut_a (
        .clk(clk), .rstn(rstn), .rx_i(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(ready_a), .frame_err(fe_a), .overrun(ovr_a)
    );
    uart_rx #(.CLKS_PER_BIT(16)) dut_b (
        .clk(clk), .rstn(rstn), .rx_i(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(ready_b), .frame_err(fe_b), .overrun(ovr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_a && ready_a) acc_a.push_back(data_a);
        if (valid_b && ready_b) acc_b.push_back(data_b);
        if (fe_a) fe_hi_a <= fe_hi_a + 1;
        if (fe_a && !fe_pa) fe_ev_a <= fe_ev_a + 1;
        if (ovr_a) ovr_hi_a <= ovr_hi_a + 1;
        if (ovr_a && !ovr_pa) ovr_ev_a <= ovr_ev_a + 1;
        if (fe_b) fe_hi_b <= fe_hi_b + 1;
        if (fe_b && !fe_pb) fe_ev_b <= fe_ev_b + 1;
        if (ovr_b) ovr_hi_b <= ovr_hi_b + 1;
        if (ovr_b && !ovr_pb) ovr_ev_b <= ovr_ev_b + 1;
        if (valid_a && !va_p) rise_a <= cyc;
        fe_pa  <= fe_a;
        ovr_pa <= ovr_a;
        fe_pb  <= fe_b;
        ovr_pb <= ovr_b;
        va_p   <= valid_a;
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives one frame; per is the bit period in hundredths of a cycle.
    // The line is left at the stop-bit level.
    task automatic send(input bit b, input logic [7:0] d, input bit stop, input int per);
        int n;
        n = (10 * per + 99) / 100;
        if (b) t0_b = cyc; else t0_a = cyc;
        for (int c = 0; c < n; c++) begin
            int k;
            logic v;
            k = c * 100 / per;
            v = (k == 0) ? 1'b0 : (k < 9) ? d[k-1] : stop;
            if (b) rx_b = v; else rx_a = v;
            step(1);
        end
    endtask

    task automatic accept(input bit b);
        if (b) ready_b = 1'b1; else ready_a = 1'b1;
        step(1);
        if (b) ready_b = 1'b0; else ready_a = 1'b0;
    endtask

    task automatic expect_byte_a(input string nm, input logic [7:0] d);
        @(negedge clk);
        chk({nm, " valid"}, int'(valid_a), 1);
        chk({nm, " data"}, int'(data_a), int'(d));
        step(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0, nbad, fe0;
        tbl[0] = '{8'h00, 1600, 8'h00};
        tbl[1] = '{8'hFF, 1600, 8'hFF};
        tbl[2] = '{8'h00, 1648, 8'h00};
        tbl[3] = '{8'hFF, 1648, 8'hFF};
        tbl[4] = '{8'h00, 1552, 8'h00};
        tbl[5] = '{8'hFF, 1552, 8'hFF};

        step(5);
        @(negedge clk);
        chk("reset valid_a", int'(valid_a), 0);
        chk("reset data_a", int'(data_a), 0);
        chk("reset frame_err_a", int'(fe_a), 0);
        chk("reset overrun_a", int'(ovr_a), 0);
        chk("reset valid_b", int'(valid_b), 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        step(5);

        // 0xA5: delivery visible in the cycle after edge 4125
        send(0, 8'hA5, 1'b1, 43400);
        expect_byte_a("a5", 8'hA5);
        chk("a5 latency", rise_a - t0_a, 4126);
        chk("a5 frame_err", fe_ev_a, 0);
        accept(0);
        @(negedge clk);
        chk("a5 cleared", int'(valid_a), 0);
        chk("a5 accepted", int'(acc_a[$]), 8'hA5);
        step(1);

        // Glitch shorter than half a bit
        rx_a = 1'b0;
        step(100);
        rx_a = 1'b1;
        step(600);
        @(negedge clk);
        chk("glitch valid", int'(valid_a), 0);
        chk("glitch frame_err", fe_ev_a, 0);
        chk("glitch overrun", ovr_ev_a, 0);
        step(1);
        send(0, 8'h3C, 1'b1, 43400);
        expect_byte_a("3c", 8'h3C);
        accept(0);

        // Bad stop bit followed by a long break
        send(0, 8'h55, 1'b0, 43400);
        step(20 * 434);
        @(negedge clk);
        chk("break frame_err events", fe_ev_a, 1);
        chk("break frame_err width", fe_hi_a, 1);
        chk("break valid", int'(valid_a), 0);
        step(1);
        rx_a = 1'b1;
        step(10);
        send(0, 8'h0F, 1'b1, 43400);
        expect_byte_a("0f", 8'h0F);
        accept(0);

        // Back-to-back with a stalled consumer: second byte is dropped
        send(0, 8'h12, 1'b1, 43400);
        send(0, 8'h34, 1'b1, 43400);
        expect_byte_a("b2b stall", 8'h12);
        chk("b2b overrun events", ovr_ev_a, 1);
        chk("b2b overrun width", ovr_hi_a, 1);
        accept(0);

        // Consumer accepts exactly at the second delivery edge
        send(0, 8'h12, 1'b1, 43400);
        n0 = acc_a.size();
        fork
            send(0, 8'h34, 1'b1, 43400);
            begin
                repeat (4125) @(posedge clk);
                #1 ready_a = 1'b1;
                @(posedge clk);
                #1 ready_a = 1'b0;
            end
        join
        @(negedge clk);
        chk("simul accepted count", acc_a.size(), n0 + 1);
        chk("simul accepted byte", int'(acc_a[$]), 8'h12);
        chk("simul data", int'(data_a), 8'h34);
        chk("simul valid", int'(valid_a), 1);
        chk("simul overrun", ovr_ev_a, 1);
        step(1);

        // Reset during data bit 4 of 0xFF while 0x34 is still pending
        fork
            send(0, 8'hFF, 1'b1, 43400);
            begin
                repeat (2400) @(posedge clk);
                #1 rstn = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("midreset valid", int'(valid_a), 0);
                chk("midreset data", int'(data_a), 0);
                chk("midreset frame_err", int'(fe_a), 0);
                chk("midreset overrun", int'(ovr_a), 0);
                @(posedge clk);
                #1 rstn = 1'b1;
            end
        join
        step(100);
        @(negedge clk);
        chk("aborted frame valid", int'(valid_a), 0);
        chk("aborted frame_err", fe_ev_a, 1);
        step(1);
        send(0, 8'h81, 1'b1, 43400);
        expect_byte_a("81", 8'h81);
        accept(0);

        // N=16 table: exact and +/-3% bit periods
        for (int i = 0; i < 6; i++) begin
            send(1, tbl[i].d, 1'b1, tbl[i].per);
            @(negedge clk);
            chk($sformatf("tbl%0d valid", i), int'(valid_b), 1);
            chk($sformatf("tbl%0d data", i), int'(data_b), int'(tbl[i].exp));
            step(1);
            accept(1);
            step(5);
        end
        chk("tbl frame_err", fe_ev_b, 0);

        // Random stream against a transaction-level scoreboard
        acc_b.delete();
        ready_b = 1'b1;
        nbad = 0;
        fe0 = fe_ev_b;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            bit bad;
            d = 8'($urandom);
            bad = ($urandom_range(0, 7) == 0);
            send(1, d, !bad, int'($urandom_range(1552, 1648)));
            if (bad) begin
                nbad++;
                rx_b = 1'b1;
                step(int'($urandom_range(2, 20)));
            end else begin
                exp_q.push_back(d);
                step(int'($urandom_range(0, 20)));
            end
        end
        step(40);
        ready_b = 1'b0;
        @(negedge clk);
        chk("rand count", acc_b.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < acc_b.size(); i++)
            chk($sformatf("rand byte %0d", i), int'(acc_b[i]), int'(exp_q[i]));
        chk("rand frame_err events", fe_ev_b - fe0, nbad);
        chk("rand frame_err width", fe_hi_b, fe_ev_b);
        chk("rand overrun", ovr_ev_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
